// File: rtl/cordic_arbiter.sv
// Round-robin front end sharing one cordic engine among NUM_REQ requesters.
// Grants one request, pulses start, waits for done under a watchdog, returns a tagged response.
module cordic_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_angle,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_cos,
    output logic [DATA_WIDTH-1:0]         rsp_sin,
    output logic                          rsp_err,
    output logic                          cordic_start,
    output logic [DATA_WIDTH-1:0]         cordic_angle,
    input  logic [DATA_WIDTH-1:0]         cordic_x,
    input  logic [DATA_WIDTH-1:0]         cordic_y,
    input  logic                          cordic_done
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StBusy, StResp} state_e;

    state_e                  state_q, state_d;
    logic [ID_W-1:0]         last_grant_q, last_grant_d;
    logic [ID_W-1:0]         id_q, id_d;
    logic [DATA_WIDTH-1:0]   angle_q, angle_d;
    logic                    start_q, start_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   cos_q, cos_d, sin_q, sin_d;
    logic                    err_q, err_d;

    logic                    any_valid;
    logic [ID_W-1:0]         grant;
    logic [ID_W-1:0]         cand;
    logic [DATA_WIDTH-1:0]   sel_angle;

    // First valid requester after the last grant, wrapping modulo NUM_REQ.
    always_comb begin
        any_valid = 1'b0;
        grant     = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
            if (!any_valid && req_valid[cand]) begin
                any_valid = 1'b1;
                grant     = cand;
            end
        end
    end

    always_comb begin
        sel_angle = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) sel_angle = req_angle[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Gated by rst_n so a requester holding valid through reset sees no accept.
    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && any_valid && rst_n) req_ready[grant] = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        angle_d      = angle_q;
        start_d      = 1'b0;
        cnt_d        = cnt_q;
        cos_d        = cos_q;
        sin_d        = sin_q;
        err_d        = err_q;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    angle_d      = sel_angle;
                    id_d         = grant;
                    last_grant_d = grant;
                    start_d      = 1'b1;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StBusy;
            end
            StBusy: begin
                // done takes priority over an expiring watchdog on the same edge
                if (cordic_done) begin
                    cos_d   = cordic_x;
                    sin_d   = cordic_y;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    cos_d   = '0;
                    sin_d   = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            angle_q      <= '0;
            start_q      <= 1'b0;
            cnt_q        <= '0;
            cos_q        <= '0;
            sin_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            angle_q      <= angle_d;
            start_q      <= start_d;
            cnt_q        <= cnt_d;
            cos_q        <= cos_d;
            sin_q        <= sin_d;
            err_q        <= err_d;
        end
    end

    assign rsp_valid    = (state_q == StResp);
    assign rsp_id       = id_q;
    assign rsp_cos      = cos_q;
    assign rsp_sin      = sin_q;
    assign rsp_err      = err_q;
    assign cordic_start = start_q;
    assign cordic_angle = angle_q;

endmodule
